// File: rtl/m_unit_seq.sv
// Sequential RISC-V M-extension unit on the PCPI bus: pipelined multiplier plus a restoring divider.
// Define M_UNIT_SEQ_DIV_EN for the full M extension; leave it undefined for multiply-only (Zmmul).
module m_unit_seq #(
  parameter int XLEN       = 32,
  parameter int DIV_BITS   = 1,
  parameter int MUL_STAGES = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            pcpi_valid,
  input  logic [31:0]     pcpi_insn,
  input  logic [XLEN-1:0] pcpi_rs1,
  input  logic [XLEN-1:0] pcpi_rs2,
  output logic [XLEN-1:0] pcpi_rd,
  output logic            pcpi_wr,
  output logic            pcpi_ready,
  output logic            pcpi_busy
);

  localparam int PW    = 2 * XLEN + 2;
  localparam int N_DIV = XLEN / DIV_BITS;
  localparam int CW    = 7;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_MUL  = 3'd1,
    S_DIV  = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t                 state, state_nxt;
  logic [CW-1:0]          cnt;
  logic [2:0]             funct3, funct3_q;
  logic                   is_mop, claim, accept;
  logic                   rd_we;
  logic [XLEN-1:0]        rd_q, rd_nxt;
  logic signed [XLEN:0]   op_a, op_b;
  logic                   sign_a, sign_b;
  logic signed [PW-1:0]   prod_p0, prod_out;
  logic [XLEN-1:0]        mul_res;

  assign funct3 = pcpi_insn[14:12];
  assign is_mop = (pcpi_insn[6:0] == 7'b0110011) && (pcpi_insn[31:25] == 7'b0000001);
`ifdef M_UNIT_SEQ_DIV_EN
  assign claim  = pcpi_valid && is_mop;
`else
  assign claim  = pcpi_valid && is_mop && !funct3[2];
`endif

  // MULHU treats rs1 as unsigned; MULHSU and MULHU treat rs2 as unsigned.
  assign sign_a = (funct3 != 3'b011);
  assign sign_b = !funct3[1];

  // Stage p0: full-width signed product of the latched operands
  assign prod_p0 = PW'(op_a) * PW'(op_b);

  generate
    if (MUL_STAGES == 0) begin : g_nopipe
      assign prod_out = prod_p0;
    end else begin : g_pipe
      logic signed [PW-1:0] prod_p [MUL_STAGES];
      // Stages p1..pN: plain register chain on the product
      always_ff @(posedge clk) begin
        if (reset) begin
          for (int k = 0; k < MUL_STAGES; k++) prod_p[k] <= '0;
        end else begin
          prod_p[0] <= prod_p0;
          for (int k = 1; k < MUL_STAGES; k++) prod_p[k] <= prod_p[k-1];
        end
      end
      assign prod_out = prod_p[MUL_STAGES-1];
    end
  endgenerate

  assign mul_res = (funct3_q[1:0] == 2'b00) ? prod_out[XLEN-1:0] : prod_out[2*XLEN-1:XLEN];

`ifdef M_UNIT_SEQ_DIV_EN
  function automatic logic [XLEN-1:0] apply_sign(input logic neg, input logic [XLEN-1:0] v);
    return neg ? -v : v;
  endfunction

  logic [XLEN-1:0] quo_q, rem_q, dvs_q;
  logic            neg_q, neg_r;
  logic            div_signed, div_zero, div_ovf;
  logic [XLEN-1:0] div_special, fix_res;
  logic [XLEN:0]   step_r;
  logic [XLEN-1:0] step_q;

  assign div_signed  = !funct3[0];
  assign div_zero    = (pcpi_rs2 == '0);
  assign div_ovf     = div_signed && (pcpi_rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (&pcpi_rs2);
  assign div_special = div_zero ? (funct3[1] ? pcpi_rs1 : '1) : (funct3[1] ? '0 : pcpi_rs1);

  // Restoring step: DIV_BITS quotient bits per cycle from the magnitude registers
  always_comb begin
    step_r = {1'b0, rem_q};
    step_q = quo_q;
    for (int i = 0; i < DIV_BITS; i++) begin
      step_r = {step_r[XLEN-1:0], step_q[XLEN-1]};
      step_q = {step_q[XLEN-2:0], 1'b0};
      if (step_r >= {1'b0, dvs_q}) begin
        step_r    = step_r - {1'b0, dvs_q};
        step_q[0] = 1'b1;
      end
    end
  end

  assign fix_res = funct3_q[1] ? apply_sign(neg_r, rem_q) : apply_sign(neg_q, quo_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      quo_q <= '0;
      rem_q <= '0;
      dvs_q <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else if (accept) begin
      quo_q <= apply_sign(div_signed && pcpi_rs1[XLEN-1], pcpi_rs1);
      dvs_q <= apply_sign(div_signed && pcpi_rs2[XLEN-1], pcpi_rs2);
      rem_q <= '0;
      neg_q <= div_signed && (pcpi_rs1[XLEN-1] ^ pcpi_rs2[XLEN-1]);
      neg_r <= div_signed && pcpi_rs1[XLEN-1];
    end else if (state == S_DIV) begin
      quo_q <= step_q;
      rem_q <= step_r[XLEN-1:0];
    end
  end
`endif

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    rd_we     = 1'b0;
    rd_nxt    = rd_q;
    case (state)
      S_IDLE: begin
        if (claim) begin
          accept = 1'b1;
          if (funct3[2]) begin
`ifdef M_UNIT_SEQ_DIV_EN
            if (div_zero || div_ovf) begin
              state_nxt = S_DONE;
              rd_we     = 1'b1;
              rd_nxt    = div_special;
            end else begin
              state_nxt = S_DIV;
            end
`endif
          end else begin
            state_nxt = S_MUL;
          end
        end
      end
      S_MUL: begin
        if (!pcpi_valid) begin
          state_nxt = S_IDLE;
        end else if (cnt == CW'(MUL_STAGES)) begin
          state_nxt = S_DONE;
          rd_we     = 1'b1;
          rd_nxt    = mul_res;
        end
      end
`ifdef M_UNIT_SEQ_DIV_EN
      S_DIV: begin
        if (!pcpi_valid) state_nxt = S_IDLE;
        else if (cnt == CW'(N_DIV - 1)) state_nxt = S_FIX;
      end
      S_FIX: begin
        if (!pcpi_valid) begin
          state_nxt = S_IDLE;
        end else begin
          state_nxt = S_DONE;
          rd_we     = 1'b1;
          rd_nxt    = fix_res;
        end
      end
`endif
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      cnt      <= '0;
      funct3_q <= '0;
      op_a     <= '0;
      op_b     <= '0;
      rd_q     <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= (state_nxt == state && state != S_IDLE) ? cnt + CW'(1) : '0;
      if (accept) begin
        funct3_q <= funct3;
        op_a     <= {sign_a && pcpi_rs1[XLEN-1], pcpi_rs1};
        op_b     <= {sign_b && pcpi_rs2[XLEN-1], pcpi_rs2};
      end
      if (rd_we) rd_q <= rd_nxt;
    end
  end

  assign pcpi_rd    = rd_q;
  assign pcpi_ready = (state == S_DONE);
  assign pcpi_wr    = (state == S_DONE);
  assign pcpi_busy  = (state == S_MUL) || (state == S_DIV) || (state == S_FIX);

  logic unused_bits;
  assign unused_bits = ^{pcpi_insn[24:15], pcpi_insn[11:7], prod_out[PW-1:2*XLEN], funct3_q[2]};

endmodule

// File: tb/tb_m_unit_seq.sv
// Bench for m_unit_seq: two instances (DIV_BITS=1/MUL_STAGES=1 and DIV_BITS=4/MUL_STAGES=2),
// directed table, multi-cycle corner sequences and random ops against an arithmetic reference.
module tb_m_unit_seq;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [1:0]       valid = '0;
  logic [31:0]      insn = '0, rs1 = '0, rs2 = '0;
  logic [1:0][31:0] rd;
  logic [1:0]       wr, ready, busy;
  int               n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  m_unit_seq #(.XLEN(32), .DIV_BITS(1), .MUL_STAGES(1)) u0 (
    .clk(clk), .reset(reset), .pcpi_valid(valid[0]), .pcpi_insn(insn),
    .pcpi_rs1(rs1), .pcpi_rs2(rs2), .pcpi_rd(rd[0]), .pcpi_wr(wr[0]),
    .pcpi_ready(ready[0]), .pcpi_busy(busy[0]));

  m_unit_seq #(.XLEN(32), .DIV_BITS(4), .MUL_STAGES(2)) u1 (
    .clk(clk), .reset(reset), .pcpi_valid(valid[1]), .pcpi_insn(insn),
    .pcpi_rs1(rs1), .pcpi_rs2(rs2), .pcpi_rd(rd[1]), .pcpi_wr(wr[1]),
    .pcpi_ready(ready[1]), .pcpi_busy(busy[1]));

  typedef struct {
    int          u;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_rd;
    int          exp_lat;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mk_insn(input logic [2:0] f3);
    return {7'b0000001, 10'h0a5, f3, 5'd3, 7'b0110011};
  endfunction

  // Reference: plain 64-bit arithmetic following the instruction definitions
  function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] a,
                                            input logic [31:0] b);
    longint sa, sb, ua, ub, p;
    int     ia, ib;
    logic [31:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'h0, a});
    ub = longint'({32'h0, b});
    ia = $signed(a);
    ib = $signed(b);
    case (f3)
      3'd0: begin p = sa * sb; r = p[31:0]; end
      3'd1: begin p = sa * sb; r = p[63:32]; end
      3'd2: begin p = sa * ub; r = p[63:32]; end
      3'd3: begin p = ua * ub; r = p[63:32]; end
      3'd4: r = (b == 0) ? 32'hffffffff : (a == 32'h80000000 && b == 32'hffffffff) ? a : 32'(ia / ib);
      3'd5: r = (b == 0) ? 32'hffffffff : a / b;
      3'd6: r = (b == 0) ? a : (a == 32'h80000000 && b == 32'hffffffff) ? 32'h0 : 32'(ia % ib);
      default: r = (b == 0) ? a : a % b;
    endcase
    return r;
  endfunction

  function automatic int exp_lat(input int u, input logic [2:0] f3, input logic [31:0] a,
                                 input logic [31:0] b);
    if (!f3[2]) return (u == 0) ? 3 : 4;
    if (b == 0 || (!f3[0] && a == 32'h80000000 && b == 32'hffffffff)) return 1;
    return (u == 0) ? 34 : 10;
  endfunction

  // Issue one op, scramble operand inputs while it runs, check result, latency and busy cycles
  task automatic exec(input int u, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] exp_rd, input int exp_l, input string name);
    logic [31:0] res;
    int lat, nbusy;
    bit got;
    @(negedge clk);
    insn = mk_insn(f3); rs1 = a; rs2 = b; valid[u] = 1'b1;
    lat = 0; nbusy = 0; got = 0; res = '0;
    while (!got && lat < 200) begin
      @(negedge clk);
      lat++;
      rs1 = $urandom; rs2 = $urandom;
      if (ready[u]) begin
        got = 1;
        res = rd[u];
        chk({name, " wr"}, 32'(wr[u]), 32'd1);
      end else if (busy[u]) begin
        nbusy++;
      end
    end
    valid[u] = 1'b0;
    chk({name, " done"}, 32'(got), 32'd1);
    if (got) begin
      chk({name, " rd"}, res, exp_rd);
      chk({name, " latency"}, 32'(lat), 32'(exp_l));
      chk({name, " busy cycles"}, 32'(nbusy), 32'(exp_l - 1));
    end
    @(negedge clk);
    chk({name, " ready/busy after"}, {30'h0, ready[u], busy[u]}, 32'h0);
  endtask

  task automatic hold_unclaimed(input int u, input logic [31:0] word, input int cycles,
                                input string name);
    int act;
    act = 0;
    @(negedge clk);
    insn = word; rs1 = 32'd7; rs2 = 32'd6; valid[u] = 1'b1;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (busy[u] || ready[u] || wr[u]) act++;
    end
    valid[u] = 1'b0;
    chk({name, " activity"}, 32'(act), 32'h0);
    chk({name, " rd"}, rd[u], 32'h0);
  endtask

  function automatic logic [31:0] rnd_op();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hffffffff;
      2: return 32'h80000000;
      3: return 32'($urandom_range(0, 9));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    vec_t tbl[$];
    logic [31:0] saved;
    int cnt_ready;

    tbl.push_back('{0, 3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 3});
    tbl.push_back('{0, 3'd3, 32'hffffffff, 32'hffffffff, 32'hfffffffe, 3});
    tbl.push_back('{0, 3'd0, 32'd7, 32'd6, 32'd42, 3});
    tbl.push_back('{1, 3'd0, 32'd7, 32'd6, 32'd42, 4});
    tbl.push_back('{1, 3'd2, 32'hffffffff, 32'hffffffff, 32'hffffffff, 4});
`ifdef M_UNIT_SEQ_DIV_EN
    tbl.push_back('{0, 3'd4, 32'hfffffff9, 32'd2, 32'hfffffffd, 34});
    tbl.push_back('{0, 3'd6, 32'hfffffff9, 32'd2, 32'hffffffff, 34});
    tbl.push_back('{1, 3'd4, 32'hfffffff9, 32'd2, 32'hfffffffd, 10});
    tbl.push_back('{1, 3'd6, 32'hfffffff9, 32'd2, 32'hffffffff, 10});
    tbl.push_back('{0, 3'd5, 32'd5, 32'd0, 32'hffffffff, 1});
    tbl.push_back('{0, 3'd7, 32'd5, 32'd0, 32'd5, 1});
    tbl.push_back('{0, 3'd4, 32'h80000000, 32'hffffffff, 32'h80000000, 1});
    tbl.push_back('{1, 3'd6, 32'h80000000, 32'hffffffff, 32'h0, 1});
`endif

    repeat (3) @(negedge clk);
    for (int u = 0; u < 2; u++) begin
      chk($sformatf("reset rd u%0d", u), rd[u], 32'h0);
      chk($sformatf("reset flags u%0d", u), {29'h0, wr[u], ready[u], busy[u]}, 32'h0);
    end
    reset = 1'b0;

    hold_unclaimed(0, {7'b0000000, 10'h0, 3'd0, 5'd3, 7'b0110011}, 5, "bad funct7");
    hold_unclaimed(1, {7'b0000001, 10'h0, 3'd0, 5'd3, 7'b0010011}, 5, "bad opcode");
`ifndef M_UNIT_SEQ_DIV_EN
    hold_unclaimed(0, mk_insn(3'd4), 40, "zmmul DIV");
    hold_unclaimed(1, mk_insn(3'd7), 12, "zmmul REMU");
`endif

    foreach (tbl[i])
      exec(tbl[i].u, tbl[i].f3, tbl[i].a, tbl[i].b, tbl[i].exp_rd, tbl[i].exp_lat,
           $sformatf("vec%0d", i));

    // Multiply abort on u1: valid dropped in the first MUL cycle
    saved = rd[1];
    @(negedge clk);
    insn = mk_insn(3'd0); rs1 = 32'd9; rs2 = 32'd9; valid[1] = 1'b1;
    @(negedge clk);
    valid[1] = 1'b0;
    cnt_ready = 0;
    @(negedge clk);
    chk("mul abort busy", {31'h0, busy[1]}, 32'h0);
    repeat (6) begin @(negedge clk); if (ready[1] || wr[1]) cnt_ready++; end
    chk("mul abort ready", 32'(cnt_ready), 32'h0);
    chk("mul abort rd", rd[1], saved);

`ifdef M_UNIT_SEQ_DIV_EN
    // Divide abort on u0: valid dropped at T+5, idle at T+6
    saved = rd[0];
    cnt_ready = 0;
    @(negedge clk);
    insn = mk_insn(3'd4); rs1 = 32'd100; rs2 = 32'd7; valid[0] = 1'b1;
    repeat (5) begin @(negedge clk); if (ready[0]) cnt_ready++; end
    chk("div busy at T+5", {31'h0, busy[0]}, 32'h1);
    valid[0] = 1'b0;
    @(negedge clk);
    chk("div abort flags T+6", {30'h0, ready[0], busy[0]}, 32'h0);
    repeat (40) begin @(negedge clk); if (ready[0] || wr[0]) cnt_ready++; end
    chk("div abort ready", 32'(cnt_ready), 32'h0);
    chk("div abort rd", rd[0], saved);
    exec(0, 3'd0, 32'd3, 32'd4, 32'd12, 3, "mul after abort");

    // Reset at T+10 of a divide
    @(negedge clk);
    insn = mk_insn(3'd5); rs1 = 32'd1000; rs2 = 32'd3; valid[0] = 1'b1;
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("mid-div reset rd", rd[0], 32'h0);
    chk("mid-div reset flags", {29'h0, wr[0], ready[0], busy[0]}, 32'h0);
    reset = 1'b0; valid[0] = 1'b0;
`endif

    // Reset coinciding with an acceptance
    exec(1, 3'd0, 32'd5, 32'd5, 32'd25, 4, "pre-reset mul");
    @(negedge clk);
    insn = mk_insn(3'd0); rs1 = 32'd3; rs2 = 32'd3; valid[1] = 1'b1; reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; valid[1] = 1'b0;
    chk("reset+accept rd", rd[1], 32'h0);
    chk("reset+accept flags", {29'h0, wr[1], ready[1], busy[1]}, 32'h0);
    @(negedge clk);
    chk("reset+accept idle", {30'h0, ready[1], busy[1]}, 32'h0);

    for (int i = 0; i < 60; i++) begin
      int u;
      logic [2:0] f3;
      logic [31:0] a, b;
      u = $urandom_range(0, 1);
`ifdef M_UNIT_SEQ_DIV_EN
      f3 = 3'($urandom_range(0, 7));
`else
      f3 = 3'($urandom_range(0, 3));
`endif
      a = rnd_op();
      b = rnd_op();
      exec(u, f3, a, b, ref_model(f3, a, b), exp_lat(u, f3, a, b),
           $sformatf("rnd%0d u%0d f3=%0d a=%08h b=%08h", i, u, f3, a, b));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/m_unit_seq.md
M_UNIT_SEQ -- requirements
Module: m_unit_seq

Interface
REQ-001 Parameter XLEN, 32, operand/result width; legal values 32 or 64.
REQ-002 Parameter DIV_BITS, 1, quotient bits resolved per DIV cycle; legal values 1, 2 or 4, and it must divide XLEN.
REQ-003 Parameter MUL_STAGES, 1, extra register stages on the product; legal values 0..2.
REQ-004 Port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-005 Port reset, input, 1, synchronous active-high reset.
REQ-006 Port pcpi_valid, input, 1, request valid; must stay high until pcpi_ready.
REQ-007 Port pcpi_insn, input, 32, instruction word.
REQ-008 Port pcpi_rs1 / pcpi_rs2, input, XLEN each, operands.
REQ-009 Port pcpi_rd, output, XLEN, registered result.
REQ-010 Port pcpi_wr, output, 1, write-back strobe.
REQ-011 Port pcpi_ready, output, 1, one-cycle completion pulse.
REQ-012 Port pcpi_busy, output, 1, computation in progress.

Function
REQ-013 Claim rule: an instruction is claimed only when pcpi_valid=1, opcode=0110011 and funct7=0000001; funct3 selects MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM or REMU.
REQ-014 States: IDLE, MUL, DIV, FIX, DONE; any unused encoding returns to IDLE on the next cycle.
REQ-015 Acceptance: a claim in IDLE (cycle T) latches funct3, rs1 and rs2; later changes on the input ports are ignored.
REQ-016 Multiply: form the 2*XLEN product of sign/zero-extended (XLEN+1)-bit operands per funct3; MUL returns the low half, the other three return the high half.
REQ-017 Multiply timing: MUL state lasts MUL_STAGES+1 cycles, then DONE; pcpi_ready is asserted at T+MUL_STAGES+2.
REQ-018 Divide: signed ops use absolute values; a restoring divider resolves DIV_BITS bits per cycle over XLEN/DIV_BITS cycles.
REQ-019 FIX (1 cycle) applies the signs: quotient negated when the operand signs differ; remainder takes the dividend's sign.
REQ-020 Divide timing: pcpi_ready is asserted at T+XLEN/DIV_BITS+2.
REQ-021 Divide by zero (IDLE->DONE directly, ready at T+1): quotient all-ones, remainder = rs1.
REQ-022 Signed overflow, rs1=-2^(XLEN-1) and rs2=-1 (ready at T+1): DIV returns rs1, REM returns 0.
REQ-023 DONE: pcpi_ready=1 and pcpi_wr=1 for exactly one cycle with pcpi_rd valid; next state is IDLE.
REQ-024 Requests are not accepted in DONE; the earliest back-to-back acceptance is the cycle after DONE.
REQ-025 pcpi_busy=1 exactly in MUL, DIV and FIX; it is 0 in IDLE and DONE.
REQ-026 Abort: pcpi_valid=0 in MUL, DIV or FIX sends the next state to IDLE with no ready/wr pulse and pcpi_rd unchanged.
REQ-027 Unclaimed requests: the block stays IDLE and all outputs stay at 0.

Reset
REQ-028 Reset sampled high at a clock edge forces IDLE and clears the counter, operand, accumulator and pipeline registers.
REQ-029 After that edge, pcpi_rd, pcpi_wr, pcpi_ready and pcpi_busy are all 0.
REQ-030 Reset has priority over every other event, including a reset arriving mid-operation or together with acceptance.

Configuration
REQ-031 Macro M_UNIT_SEQ_DIV_EN: defined = full M extension; undefined = multiply-only (Zmmul).
REQ-032 With M_UNIT_SEQ_DIV_EN undefined, divide funct3 values are unclaimed per REQ-027, and the DIV/FIX logic and divider registers are absent.

Verification
REQ-033 XLEN=32, MUL_STAGES=1: MULH 0x80000000*0x80000000 -> pcpi_rd=0x40000000, ready at T+3; MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE.
REQ-034 DIV_BITS=1: DIV 0xFFFFFFF9/2 -> 0xFFFFFFFD and REM -> 0xFFFFFFFF, both ready at T+34; repeat with DIV_BITS=4 -> same values, ready at T+10.
REQ-035 DIVU 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM of the same -> 0; all ready at T+1.
REQ-036 Mid-operation events during DIV: pcpi_valid dropped at T+5 -> IDLE at T+6 with no ready; a following MUL 3*4 -> 12; reset at T+10 -> all outputs 0 next cycle.
REQ-037 M_UNIT_SEQ_DIV_EN undefined: DIV held valid for 40 cycles -> busy and ready stay 0; MUL 7*6 -> 42.
